// File: rtl/ctrl_decode.sv
// ctrl_decode: single-stage instruction decoder with a valid/ready handshake.
// Decodes 16-bit instruction words into a registered control bundle, keeps the
// carry/borrow flags for ADDC/SUBB, and handles the HALT and soft-RESET system
// commands through a small RUN/SRST/HALTED state machine.
module ctrl_decode (
    input  logic        clk_pi,
    input  logic        rst_n_pi,
    input  logic [15:0] instr_pi,
    input  logic        instr_valid_pi,
    output logic        instr_ready_po,
    output logic        dec_valid_po,
    input  logic        dec_ready_pi,
    output logic        arith_1op_po,
    output logic        arith_2op_po,
    output logic        addi_po,
    output logic        subi_po,
    output logic        load_or_store_po,
    output logic        stc_cmd_po,
    output logic        stb_cmd_po,
    output logic        branch_po,
    output logic        jump_po,
    output logic        reg_write_po,
    output logic        mem_write_po,
    output logic [2:0]  alu_func_po,
    output logic [5:0]  immediate_po,
    output logic [2:0]  rd_po,
    output logic [2:0]  rs1_po,
    output logic [2:0]  rs2_po,
    output logic [1:0]  cond_po,
    input  logic        flag_we_pi,
    input  logic        carry_out_pi,
    input  logic        borrow_out_pi,
    output logic        carry_in_po,
    output logic        borrow_in_po,
    output logic        halted_po,
    output logic        soft_reset_po,
    output logic        illegal_po
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SRST   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Everything that travels with one decoded instruction.
    typedef struct packed {
        logic       arith_1op;
        logic       arith_2op;
        logic       addi;
        logic       subi;
        logic       load_or_store;
        logic       stc_cmd;
        logic       stb_cmd;
        logic       branch;
        logic       jump;
        logic       reg_write;
        logic       mem_write;
        logic [2:0] alu_func;
        logic [5:0] imm;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [1:0] cond;
        logic       illegal;
    } bundle_t;

    state_t     r_state;
    state_t     w_state_nxt;
    bundle_t    r_bundle;
    bundle_t    w_dec;
    logic       r_dec_valid;
    logic       r_carry;
    logic       r_borrow;
    logic       w_ready;
    logic       w_accept;
    logic [3:0] w_opcode;
    logic [11:0] w_ctrl12;
    logic       w_is_halt;
    logic       w_is_rst;

    assign w_opcode  = instr_pi[15:12];
    assign w_ctrl12  = instr_pi[11:0];
    assign w_is_halt = (w_opcode == 4'hF) && (w_ctrl12 == 12'hFFF);
    assign w_is_rst  = (w_opcode == 4'hF) && (w_ctrl12 == 12'hAAA);

    // State register; reset lands in RUN.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake: only RUN accepts, and only when the output slot frees up.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_ready  = !r_dec_valid || dec_ready_pi;
                w_accept = instr_valid_pi && w_ready;
                if (w_accept && w_is_halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_accept && w_is_rst) begin
                    w_state_nxt = ST_SRST;
                end
            end
            ST_SRST:   w_state_nxt = ST_RUN;
            ST_HALTED: w_state_nxt = ST_HALTED;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    // Combinational decode of the incoming word; fields always pass straight through.
    always_comb begin
        w_dec          = '0;
        w_dec.alu_func = instr_pi[2:0];
        w_dec.imm      = instr_pi[5:0];
        w_dec.rd       = instr_pi[11:9];
        w_dec.rs1      = instr_pi[8:6];
        w_dec.rs2      = instr_pi[5:3];
        case (w_opcode)
            4'h1: begin
                w_dec.arith_2op = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            4'h2: begin
                w_dec.arith_1op = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            4'h3: w_dec.reg_write = 1'b1;
            4'h4: begin
                w_dec.addi      = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            4'h5: begin
                w_dec.subi      = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            4'h6: begin
                w_dec.load_or_store = 1'b1;
                w_dec.reg_write     = 1'b1;
            end
            4'h7: begin
                w_dec.load_or_store = 1'b1;
                w_dec.mem_write     = 1'b1;
            end
            4'h8, 4'h9, 4'hA, 4'hB: begin
                w_dec.branch = 1'b1;
                w_dec.cond   = w_opcode[1:0];
            end
            4'hC: w_dec.jump = 1'b1;
            4'hD, 4'hE: w_dec.illegal = 1'b1;
            4'hF: begin
                if (w_ctrl12 == 12'h001) begin
                    w_dec.stc_cmd = 1'b1;
                end else if (w_ctrl12 == 12'h002) begin
                    w_dec.stb_cmd = 1'b1;
                end else if (!w_is_halt && !w_is_rst) begin
                    w_dec.illegal = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output bundle: load on accept, hold while stalled, clear once consumed.
    // HALT/RESET words are consumed here without producing a bundle.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            r_dec_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (w_accept) begin
            if (w_is_halt || w_is_rst) begin
                r_dec_valid <= 1'b0;
                r_bundle    <= '0;
            end else begin
                r_dec_valid <= 1'b1;
                r_bundle    <= w_dec;
            end
        end else if (dec_ready_pi) begin
            r_dec_valid <= 1'b0;
            r_bundle    <= '0;
        end
    end

    // Flags: soft reset (its acceptance and the SRST cycle) overrides any ALU write.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else if ((r_state == ST_SRST) || (w_accept && w_is_rst)) begin
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else if (flag_we_pi) begin
            r_carry  <= carry_out_pi;
            r_borrow <= borrow_out_pi;
        end
    end

    assign instr_ready_po   = w_ready;
    assign dec_valid_po     = r_dec_valid;
    assign arith_1op_po     = r_bundle.arith_1op;
    assign arith_2op_po     = r_bundle.arith_2op;
    assign addi_po          = r_bundle.addi;
    assign subi_po          = r_bundle.subi;
    assign load_or_store_po = r_bundle.load_or_store;
    assign stc_cmd_po       = r_bundle.stc_cmd;
    assign stb_cmd_po       = r_bundle.stb_cmd;
    assign branch_po        = r_bundle.branch;
    assign jump_po          = r_bundle.jump;
    assign reg_write_po     = r_bundle.reg_write;
    assign mem_write_po     = r_bundle.mem_write;
    assign alu_func_po      = r_bundle.alu_func;
    assign immediate_po     = r_bundle.imm;
    assign rd_po            = r_bundle.rd;
    assign rs1_po           = r_bundle.rs1;
    assign rs2_po           = r_bundle.rs2;
    assign cond_po          = r_bundle.cond;
    assign illegal_po       = r_bundle.illegal;
    assign carry_in_po      = r_carry;
    assign borrow_in_po     = r_borrow;
    assign halted_po        = (r_state == ST_HALTED);
    assign soft_reset_po    = (r_state == ST_SRST);

endmodule

// File: tb/tb_ctrl_decode.sv
// Testbench for ctrl_decode: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        dec_ready = 1'b0;
    logic        flag_we = 1'b0;
    logic        carry_out = 1'b0;
    logic        borrow_out = 1'b0;

    logic        instr_ready, dec_valid;
    logic        arith_1op, arith_2op, addi, subi, lors, stc, stb, branch, jump, reg_write, mem_write;
    logic [2:0]  alu_func, rd, rs1, rs2;
    logic [5:0]  imm;
    logic [1:0]  cond;
    logic        carry_in, borrow_in, halted, soft_reset, illegal;

    int n_chk  = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    ctrl_decode dut (
        .clk_pi(clk), .rst_n_pi(rst_n), .instr_pi(instr), .instr_valid_pi(instr_valid),
        .instr_ready_po(instr_ready), .dec_valid_po(dec_valid), .dec_ready_pi(dec_ready),
        .arith_1op_po(arith_1op), .arith_2op_po(arith_2op), .addi_po(addi), .subi_po(subi),
        .load_or_store_po(lors), .stc_cmd_po(stc), .stb_cmd_po(stb), .branch_po(branch),
        .jump_po(jump), .reg_write_po(reg_write), .mem_write_po(mem_write),
        .alu_func_po(alu_func), .immediate_po(imm), .rd_po(rd), .rs1_po(rs1), .rs2_po(rs2),
        .cond_po(cond), .flag_we_pi(flag_we), .carry_out_pi(carry_out), .borrow_out_pi(borrow_out),
        .carry_in_po(carry_in), .borrow_in_po(borrow_in), .halted_po(halted),
        .soft_reset_po(soft_reset), .illegal_po(illegal)
    );

    logic [31:0] act_bundle;
    assign act_bundle = {arith_1op, arith_2op, addi, subi, lors, stc, stb, branch, jump,
                         reg_write, mem_write, alu_func, imm, rd, rs1, rs2, cond, illegal};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bundle for a word, straight from the opcode table.
    function automatic logic [31:0] model_decode(input logic [15:0] w);
        int op, c12;
        logic sys, a1, a2, ai, si, ls, sc, sb, br, jp, rw, mw, ill;
        logic [1:0] cd;
        op  = int'(w[15:12]);
        c12 = int'(w[11:0]);
        sys = (op == 15);
        a2  = (op == 1);
        a1  = (op == 2);
        ai  = (op == 4);
        si  = (op == 5);
        ls  = (op == 6) || (op == 7);
        sc  = sys && (c12 == 1);
        sb  = sys && (c12 == 2);
        br  = (op >= 8) && (op <= 11);
        jp  = (op == 12);
        rw  = (op >= 1) && (op <= 6);
        mw  = (op == 7);
        ill = (op == 13) || (op == 14) || (sys && c12 != 1 && c12 != 2);
        cd  = br ? 2'(op % 4) : 2'd0;
        return {a1, a2, ai, si, ls, sc, sb, br, jp, rw, mw,
                w[2:0], w[5:0], w[11:9], w[8:6], w[5:3], cd, ill};
    endfunction

    // Behavioural model state.
    logic        m_valid = 1'b0;
    logic [31:0] m_bundle = '0;
    logic        m_halted = 1'b0;
    logic        m_srst = 1'b0;
    logic        m_c = 1'b0;
    logic        m_b = 1'b0;
    logic        m_ready, m_acc, m_halt_cmd, m_rst_cmd;

    // Model: what the decoder may accept this cycle.
    always_comb begin
        m_ready    = !m_halted && !m_srst && (!m_valid || dec_ready);
        m_acc      = instr_valid && m_ready;
        m_halt_cmd = (instr == 16'hFFFF);
        m_rst_cmd  = (instr == 16'hFAAA);
    end

    // Model: state advance per clock, cleared immediately by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_bundle <= '0;
            m_halted <= 1'b0;
            m_srst   <= 1'b0;
            m_c      <= 1'b0;
            m_b      <= 1'b0;
        end else begin
            m_srst <= m_acc && m_rst_cmd;
            if (m_acc && m_halt_cmd) m_halted <= 1'b1;
            if (m_acc && !m_halt_cmd && !m_rst_cmd) begin
                m_valid  <= 1'b1;
                m_bundle <= model_decode(instr);
            end else if (m_acc || dec_ready) begin
                m_valid  <= 1'b0;
                m_bundle <= '0;
            end
            if (m_srst || (m_acc && m_rst_cmd)) begin
                m_c <= 1'b0;
                m_b <= 1'b0;
            end else if (flag_we) begin
                m_c <= carry_out;
                m_b <= borrow_out;
            end
        end
    end

    // Compare the DUT against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("dec_valid", 32'(dec_valid), 32'(m_valid));
            chk("instr_ready", 32'(instr_ready), 32'(m_ready));
            chk("bundle", act_bundle, m_bundle);
            chk("flags", {30'd0, carry_in, borrow_in}, {30'd0, m_c, m_b});
            chk("halted", 32'(halted), 32'(m_halted));
            chk("soft_reset", 32'(soft_reset), 32'(m_srst));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(); cyc();
        cmp_en = 1'b1;
        // Reset state.
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_bundle", act_bundle, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        // Two-operand arithmetic.
        instr = 16'h1A51; instr_valid = 1'b1; dec_ready = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("t31_valid", 32'(dec_valid), 32'd1);
        chk("t31_arith2", 32'(arith_2op), 32'd1);
        chk("t31_func", 32'(alu_func), 32'd1);
        chk("t31_regs", {23'd0, rd, rs1, rs2}, {23'd0, 3'd5, 3'd1, 3'd2});
        chk("t31_rw", 32'(reg_write), 32'd1);

        // Stalled ADDI must hold.
        cyc();
        instr = 16'h40C7; instr_valid = 1'b1; dec_ready = 1'b0;
        cyc();
        instr = 16'h1A51;
        for (int i = 0; i < 3; i++) begin
            chk("t32_addi", 32'(addi), 32'd1);
            chk("t32_imm", 32'(imm), 32'h07);
            chk("t32_ready", 32'(instr_ready), 32'd0);
            chk("t32_valid", 32'(dec_valid), 32'd1);
            cyc();
        end
        instr_valid = 1'b0; dec_ready = 1'b1;
        cyc();
        chk("t32_consumed", 32'(dec_valid), 32'd0);

        // Flag write then soft reset; a flag write during SRST is ignored.
        flag_we = 1'b1; carry_out = 1'b1;
        cyc();
        flag_we = 1'b0; carry_out = 1'b0;
        chk("t33_carry", 32'(carry_in), 32'd1);
        instr = 16'hFAAA; instr_valid = 1'b1;
        cyc();
        instr_valid = 1'b0;
        flag_we = 1'b1; carry_out = 1'b1; borrow_out = 1'b1;
        chk("t33_srst", 32'(soft_reset), 32'd1);
        chk("t33_nobundle", 32'(dec_valid), 32'd0);
        chk("t33_carry_clr", 32'(carry_in), 32'd0);
        cyc();
        flag_we = 1'b0; carry_out = 1'b0; borrow_out = 1'b0;
        chk("t33_srst_end", 32'(soft_reset), 32'd0);
        chk("t33_we_ignored", {30'd0, carry_in, borrow_in}, 32'd0);

        // Illegal opcode and STC.
        instr = 16'hD000; instr_valid = 1'b1;
        cyc();
        instr = 16'hF001;
        chk("t35_ill", 32'(illegal), 32'd1);
        chk("t35_nop", act_bundle, 32'd1);
        cyc();
        instr_valid = 1'b0;
        chk("t35_stc", 32'(stc), 32'd1);
        chk("t35_ill_clr", 32'(illegal), 32'd0);
        cyc();

        // HALT, flag writes still land, only rst_n gets out.
        instr = 16'hFFFF; instr_valid = 1'b1;
        cyc();
        instr = 16'h1A51;
        for (int i = 0; i < 20; i++) begin
            flag_we = (i == 5); carry_out = (i == 5);
            chk("t34_halted", 32'(halted), 32'd1);
            chk("t34_ready", 32'(instr_ready), 32'd0);
            cyc();
        end
        flag_we = 1'b0; carry_out = 1'b0;
        chk("t34_flag_halted", 32'(carry_in), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t34_rst_halted", 32'(halted), 32'd0);
        chk("t34_rst_out", {act_bundle[31:1], carry_in}, 32'd0);
        cyc();
        rst_n = 1'b1; instr_valid = 1'b0;
        cyc();

        // Asynchronous reset mid-cycle drops a pending bundle.
        instr = 16'h1A51; instr_valid = 1'b1; dec_ready = 1'b0;
        cyc();
        instr_valid = 1'b0;
        chk("t36_pending", 32'(dec_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t36_async", 32'(dec_valid), 32'd0);
        chk("t36_bundle", act_bundle, 32'd0);
        cyc();
        rst_n = 1'b1; instr = 16'h40C7; instr_valid = 1'b1; dec_ready = 1'b1;
        cyc();
        instr_valid = 1'b0;
        chk("t30_first_acc", {30'd0, dec_valid, addi}, 32'd3);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)       instr = 16'hFFFF;
            else if (r < 8)  instr = 16'hFAAA;
            else if (r < 14) instr = 16'hF001;
            else if (r < 20) instr = 16'hF002;
            else if (r < 25) instr = {4'hF, 12'($urandom)};
            else             instr = 16'($urandom);
            instr_valid = ($urandom_range(0, 3) != 0);
            dec_ready   = ($urandom_range(0, 2) != 0);
            flag_we     = ($urandom_range(0, 3) == 0);
            carry_out   = 1'($urandom);
            borrow_out  = 1'($urandom);
            rst_n       = ($urandom_range(0, 99) >= 3);
            cyc();
        end
        rst_n = 1'b1;
        cyc();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ctrl_decode.md
CTRL_DECODE -- requirements
Module: ctrl_decode

Interface
REQ-001 SHALL have port clk_pi  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_pi  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port instr_pi  input  16  instruction word; [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6, [2:0] func, [11:0] ctrl12.
REQ-004 SHALL have port instr_valid_pi  input  1  instr_pi is valid.
REQ-005 SHALL have port instr_ready_po  output  1  block accepts instr_pi this cycle.
REQ-006 SHALL have port dec_valid_po  output  1  decoded bundle is valid.
REQ-007 SHALL have port dec_ready_pi  input  1  downstream consumes the bundle.
REQ-008 SHALL have ports arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po, branch_po, jump_po, reg_write_po, mem_write_po  output  1 each  registered decoded controls.
REQ-009 SHALL have ports alu_func_po  output  3; immediate_po  output  6; rd_po, rs1_po, rs2_po  output  3 each; cond_po  output  2 (00 BEQ, 01 BGE, 10 BLE, 11 BC).
REQ-010 SHALL have ports flag_we_pi  input  1, carry_out_pi  input  1, borrow_out_pi  input  1  ALU flag writeback.
REQ-011 SHALL have ports carry_in_po, borrow_in_po  output  1 each  current flag values for ADDC/SUBB.
REQ-012 SHALL have ports halted_po  output  1, soft_reset_po  output  1, illegal_po  output  1.

Function
REQ-013 SHALL implement FSM states RUN, SRST, HALTED; reset state RUN.
REQ-014 In RUN, instr_ready_po SHALL equal (!dec_valid_po || dec_ready_pi); 0 in SRST and HALTED.
REQ-015 Instruction accepted when instr_valid_pi && instr_ready_po; bundle registered, dec_valid_po=1 next cycle (latency 1).
REQ-016 While dec_valid_po && !dec_ready_pi, every decoded output SHALL hold stable.
REQ-017 If dec_ready_pi and no acceptance, dec_valid_po SHALL clear next cycle; accept+consume same cycle gives back-to-back bundles, full throughput.
REQ-018 Decode: 0001 arith_2op, 0010 arith_1op, 0011 MOVI, 0100 addi, 0101 subi, 0110 load, 0111 store, 1000-1011 branch_po with cond_po=opcode[1:0], 1100 jump_po; alu_func_po=func.
REQ-019 reg_write_po=1 for 0001-0110; mem_write_po=1 for 0111 only; load_or_store_po=1 for 0110/0111.
REQ-020 Fields (rd, rs1, rs2, imm6, func) SHALL pass through unmodified for every opcode; non-decoded controls 0.
REQ-021 0000 NOP SHALL produce a valid bundle with all control outputs 0.
REQ-022 1111 with ctrl12 000000000001 (STC) / 000000000010 (STB) SHALL assert stc_cmd_po / stb_cmd_po in the bundle.
REQ-023 1111 with ctrl12 111111111111 (HALT) SHALL produce no bundle, enter HALTED, halted_po=1 until rst_n_pi.
REQ-024 1111 with ctrl12 101010101010 (RESET) SHALL produce no bundle, enter SRST one cycle, pulse soft_reset_po one cycle, clear both flags, return RUN.
REQ-025 Opcodes 1101, 1110 and unlisted ctrl12 SHALL decode as NOP and pulse illegal_po one cycle with the bundle.
REQ-026 Flag regs SHALL load carry_out_pi/borrow_out_pi on flag_we_pi; carry_in_po/borrow_in_po driven from flag regs.
REQ-027 flag_we_pi during SRST SHALL be ignored (soft reset wins); flag writes in HALTED SHALL still apply.
REQ-028 A pending bundle (valid, unconsumed) when HALT/RESET arrives cannot occur: control word only accepted when instr_ready_po=1; pending bundle kept until consumed.

Reset
REQ-029 rst_n_pi low SHALL immediately force state RUN, dec_valid_po=0, all decoded outputs 0, flags 0, halted_po=0, soft_reset_po=0, illegal_po=0, regardless of clock.
REQ-030 Reset asserted mid-handshake SHALL drop the pending bundle; first acceptance possible on first clock edge after release.

Verification
REQ-031 instr 16'h1A51 valid, dec_ready_pi=1 -> next cycle arith_2op=1, alu_func=001, rd=5, rs1=1, rs2=2, reg_write=1.
REQ-032 instr 16'h4 0C7 -> bundle; dec_ready_pi=0 three cycles -> outputs stable, instr_ready_po=0; then consumed; addi=1, imm=000111.
REQ-033 flag_we_pi=1, carry_out_pi=1 -> carry_in_po=1 next cycle; then instr 16'hFAAA -> soft_reset_po one-cycle pulse, carry_in_po=0, no bundle.
REQ-034 instr 16'hFFFF -> halted_po=1, instr_ready_po=0 for 20 cycles with instr_valid_pi=1; rst_n_pi pulse low -> RUN, all outputs 0.
REQ-035 instr 16'hD000 -> NOP bundle, illegal_po=1 one cycle; 16'hF001 -> stc_cmd_po=1, illegal_po=0.
REQ-036 rst_n_pi low mid-cycle while dec_valid_po=1 -> dec_valid_po=0 before next clock edge.
